// File: rtl/uart_rx_param_if.sv
// Byte-stream output of the UART receiver: FIFO head data with a valid/ready handshake.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  // rx_valid is high while rx_out holds an unread entry and does not depend on rx_ready;
  // an entry is consumed on every rising clock edge where rx_valid && rx_ready.
  logic [DATA_BITS-1:0] rx_out;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output rx_out, output rx_valid, input rx_ready);
  modport slave  (input rx_out, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority vote, optional
// parity, 1 or 2 stop bits and a valid/ready output FIFO with overrun reporting.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            rx_clk,
  input  logic            rx_rst_n,
  input  logic            rx_en,
  input  logic            rx_in,
  output logic            rx_busy,
  output logic            rx_frame_err,
  output logic            rx_parity_err,
  output logic            rx_overrun,
  output logic [2:0]      rx_state,
  uart_rx_param_if.master rx_if
);
  localparam int M  = OVERSAMPLE / 2;
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LO   = CW'(M - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(M);
  localparam logic [CW-1:0] CNT_DEC  = CW'(M + 1);
  localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
  localparam logic          ODD      = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state, state_n;
  logic                 sync_q, rxs;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 smp_lo, smp_mid, armed, stop_bad, par_bad;
  logic                 decide, bit_end, vote, frame_done, stop_fail;
  logic                 push, pop, push_ok, full, empty;
  logic [AW:0]          wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

  assign decide    = (cnt == CNT_DEC);
  assign bit_end   = (cnt == CNT_END);
  assign vote      = (smp_lo & smp_mid) | (smp_lo & rxs) | (smp_mid & rxs);
  assign stop_fail = stop_bad | ~vote;

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) state <= S_IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n    = state;
    frame_done = 1'b0;
    case (state)
      S_IDLE:   if (armed && !rxs) state_n = S_START;
      S_START: begin
        if (decide && vote) state_n = S_IDLE;
        else if (bit_end)   state_n = S_DATA;
      end
      S_DATA:   if (bit_end && idx == LAST_IDX) state_n = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_n = S_STOP;
      // Leave on the last stop decision, not the bit end, so a back-to-back start is seen.
      S_STOP: begin
        if (decide && (STOP_BITS == 1 || idx == IW'(1))) begin
          state_n    = S_IDLE;
          frame_done = 1'b1;
        end
      end
      default:  state_n = S_IDLE;
    endcase
    if (!rx_en) begin
      state_n    = S_IDLE;
      frame_done = 1'b0;
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      sync_q        <= 1'b1;
      rxs           <= 1'b1;
      cnt           <= '0;
      idx           <= '0;
      shreg         <= '0;
      smp_lo        <= 1'b1;
      smp_mid       <= 1'b1;
      armed         <= 1'b1;
      stop_bad      <= 1'b0;
      par_bad       <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      sync_q        <= rx_in;
      rxs           <= sync_q;
      rx_frame_err  <= frame_done & stop_fail;
      rx_parity_err <= frame_done & par_bad;
      rx_overrun    <= push & ~push_ok;

      if (state == S_IDLE || state_n == S_IDLE || bit_end) cnt <= '0;
      else                                                 cnt <= cnt + CW'(1);

      if (cnt == CNT_LO)  smp_lo  <= rxs;
      if (cnt == CNT_MID) smp_mid <= rxs;

      if (state == S_DATA && decide) shreg <= {vote, shreg[DATA_BITS-1:1]};

      case (state)
        S_IDLE: begin
          idx      <= '0;
          stop_bad <= 1'b0;
          par_bad  <= 1'b0;
        end
        S_DATA:   if (bit_end) idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
        S_PARITY: if (decide) par_bad <= vote ^ (^shreg) ^ ODD;
        S_STOP: begin
          if (decide)  stop_bad <= stop_bad | ~vote;
          if (bit_end) idx <= idx + IW'(1);
        end
        default: ;
      endcase

      // After a framing error the line must be seen high before another start is trusted.
      if (frame_done && stop_fail)    armed <= 1'b0;
      else if (state == S_IDLE && rxs) armed <= 1'b1;
    end
  end

  assign push    = frame_done & ~stop_fail & ~par_bad;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = ~empty & rx_if.rx_ready;
  assign push_ok = push & (~full | pop);

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge rx_clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  assign rx_if.rx_out   = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign rx_if.rx_valid = ~empty;
  assign rx_busy        = (state != S_IDLE);
  assign rx_state       = state;
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench: default 8N1 receiver (a) and an even-parity, 2-stop-bit receiver (b).
module tb_uart_rx_param;
  localparam int OS = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_a = 1'b1, en_b = 1'b1;
  logic line_a = 1'b1, line_b = 1'b1;
  logic busy_a, ferr_a, perr_a, ovr_a;
  logic busy_b, ferr_b, perr_b, ovr_b;
  logic [2:0] st_a, st_b;

  int n_checks = 0, n_fail = 0;
  int cnt_ferr_a = 0, cnt_perr_a = 0, cnt_ovr_a = 0, pops_a = 0;
  int cnt_ferr_b = 0, cnt_perr_b = 0, cnt_ovr_b = 0, pops_b = 0;
  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];

  uart_rx_param_if #(.DATA_BITS(8)) if_a ();
  uart_rx_param_if #(.DATA_BITS(8)) if_b ();

  uart_rx_param dut_a (
    .rx_clk(clk), .rx_rst_n(rst_n), .rx_en(en_a), .rx_in(line_a),
    .rx_busy(busy_a), .rx_frame_err(ferr_a), .rx_parity_err(perr_a),
    .rx_overrun(ovr_a), .rx_state(st_a), .rx_if(if_a)
  );

  uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_b (
    .rx_clk(clk), .rx_rst_n(rst_n), .rx_en(en_b), .rx_in(line_b),
    .rx_busy(busy_b), .rx_frame_err(ferr_b), .rx_parity_err(perr_b),
    .rx_overrun(ovr_b), .rx_state(st_b), .rx_if(if_b)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int sel, input logic [15:0] bits, input int n, input int glitch_bit);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < OS; j++) begin
        logic v;
        v = bits[i] ^ ((i == glitch_bit) && (j == OS / 2));
        if (sel == 0) line_a = v;
        else          line_b = v;
        tick();
      end
    end
  endtask

  function automatic logic [15:0] frame_a(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  function automatic logic [15:0] frame_b(input logic [7:0] d, input logic par, input logic stop2);
    return {4'b0, stop2, 1'b1, par, d, 1'b0};
  endfunction

  // Scoreboard: pulse counters and in-order comparison of every popped byte.
  always @(negedge clk) begin
    if (ferr_a) cnt_ferr_a++;
    if (perr_a) cnt_perr_a++;
    if (ovr_a)  cnt_ovr_a++;
    if (ferr_b) cnt_ferr_b++;
    if (perr_b) cnt_perr_b++;
    if (ovr_b)  cnt_ovr_b++;
    if (if_a.rx_valid && if_a.rx_ready) begin
      pops_a++;
      if (exp_q_a.size() == 0) check_val("pop_a_extra", 32'(exp_q_a.size()), 32'd1);
      else                     check_val("pop_a_data", 32'(if_a.rx_out), 32'(exp_q_a.pop_front()));
    end
    if (if_b.rx_valid && if_b.rx_ready) begin
      pops_b++;
      if (exp_q_b.size() == 0) check_val("pop_b_extra", 32'(exp_q_b.size()), 32'd1);
      else                     check_val("pop_b_data", 32'(if_b.rx_out), 32'(exp_q_b.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, p, pb, fb0;
    if_a.rx_ready = 1'b1;
    if_b.rx_ready = 1'b1;
    repeat (3) tick();
    check_val("rst_valid_a", 32'(if_a.rx_valid), 0);
    check_val("rst_out_a", 32'(if_a.rx_out), 0);
    check_val("rst_busy_a", 32'(busy_a), 0);
    check_val("rst_state_a", 32'(st_a), 0);
    check_val("rst_flags_a", 32'({ferr_a, perr_a, ovr_a}), 0);
    check_val("rst_valid_b", 32'(if_b.rx_valid), 0);
    rst_n = 1'b1;
    repeat (4) tick();

    // 0xA5, cycle-exact: decision at T0+154, rx_valid for one cycle at T0+155.
    exp_q_a.push_back(8'hA5);
    fork
      send(0, frame_a(8'hA5), 10, -1);
      begin
        repeat (156) tick();
        check_val("a5_valid_t154", 32'(if_a.rx_valid), 0);
        check_val("a5_busy_t154", 32'(busy_a), 1);
        tick();
        check_val("a5_valid_t155", 32'(if_a.rx_valid), 1);
        check_val("a5_data_t155", 32'(if_a.rx_out), 32'hA5);
        check_val("a5_busy_t155", 32'(busy_a), 0);
        tick();
        check_val("a5_valid_t156", 32'(if_a.rx_valid), 0);
      end
    join
    check_val("a5_no_flags", cnt_ferr_a + cnt_perr_a + cnt_ovr_a, 0);

    // Three-clock low pulse while idle: start is rejected by the vote.
    p = pops_a;
    line_a = 1'b0;
    repeat (3) tick();
    line_a = 1'b1;
    check_val("glitch_busy", 32'(busy_a), 1);
    repeat (30) tick();
    check_val("glitch_idle", 32'(busy_a), 0);
    check_val("glitch_no_push", pops_a - p, 0);
    check_val("glitch_no_flags", cnt_ferr_a + cnt_perr_a, 0);

    // Single-cycle inversions mid-bit inside valid frames.
    exp_q_a.push_back(8'hC3);
    send(0, frame_a(8'hC3), 10, 1);
    exp_q_a.push_back(8'h3C);
    send(0, frame_a(8'h3C), 10, 3);
    repeat (4) tick();
    check_val("vote_pops", pops_a - p, 2);

    // Overrun: four stored, fifth dropped with a one-cycle pulse.
    if_a.rx_ready = 1'b0;
    base = cnt_ovr_a;
    for (int k = 1; k <= 4; k++) begin
      exp_q_a.push_back(8'(k));
      send(0, frame_a(8'(k)), 10, -1);
    end
    repeat (4) tick();
    check_val("ovr_none_at_4", cnt_ovr_a - base, 0);
    check_val("full_valid", 32'(if_a.rx_valid), 1);
    send(0, frame_a(8'h05), 10, -1);
    repeat (4) tick();
    check_val("ovr_on_5th", cnt_ovr_a - base, 1);
    check_val("full_head", 32'(if_a.rx_out), 32'h01);
    p = pops_a;
    if_a.rx_ready = 1'b1;
    repeat (8) tick();
    check_val("drain_pops", pops_a - p, 4);
    check_val("drain_empty", 32'(if_a.rx_valid), 0);

    // Full FIFO with a pop on the push edge: the fifth byte is kept.
    if_a.rx_ready = 1'b0;
    base = cnt_ovr_a;
    for (int k = 0; k < 5; k++) exp_q_a.push_back(8'h11 + 8'(k));
    for (int k = 0; k < 4; k++) send(0, frame_a(8'h11 + 8'(k)), 10, -1);
    fork
      send(0, frame_a(8'h15), 10, -1);
      begin
        repeat (156) tick();
        if_a.rx_ready = 1'b1;
        tick();
        if_a.rx_ready = 1'b0;
      end
    join
    check_val("popush_no_ovr", cnt_ovr_a - base, 0);
    check_val("popush_head", 32'(if_a.rx_out), 32'h12);
    p = pops_a;
    if_a.rx_ready = 1'b1;
    repeat (8) tick();
    check_val("popush_drain", pops_a - p, 4);

    // rx_en dropped mid-data: frame discarded silently.
    p = pops_a;
    base = cnt_ferr_a + cnt_perr_a;
    fork
      send(0, frame_a(8'h5A), 10, -1);
      begin
        repeat (60) tick();
        check_val("abort_busy_before", 32'(busy_a), 1);
        en_a = 1'b0;
        tick();
        check_val("abort_busy_after", 32'(busy_a), 0);
      end
    join
    repeat (4) tick();
    check_val("abort_no_push", pops_a - p, 0);
    check_val("abort_no_flags", cnt_ferr_a + cnt_perr_a - base, 0);
    en_a = 1'b1;

    // Asynchronous reset mid-frame empties the FIFO.
    if_a.rx_ready = 1'b0;
    send(0, frame_a(8'h33), 10, -1);
    repeat (4) tick();
    check_val("pre_rst_head", 32'(if_a.rx_out), 32'h33);
    fork
      send(0, frame_a(8'h44), 10, -1);
      begin
        repeat (80) tick();
        check_val("pre_rst_busy", 32'(busy_a), 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_valid", 32'(if_a.rx_valid), 0);
        check_val("arst_out", 32'(if_a.rx_out), 0);
        check_val("arst_busy", 32'(busy_a), 0);
      end
    join
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check_val("post_rst_empty", 32'(if_a.rx_valid), 0);
    p = pops_a;
    if_a.rx_ready = 1'b1;
    exp_q_a.push_back(8'h96);
    send(0, frame_a(8'h96), 10, -1);
    repeat (4) tick();
    check_val("post_rst_rx", pops_a - p, 1);

    // Receiver b: even parity. 0x07 has three ones, so its parity bit must be 1.
    pb = cnt_perr_b;
    fb0 = cnt_ferr_b;
    p = pops_b;
    send(1, frame_b(8'h07, 1'b0, 1'b1), 12, -1);
    repeat (4) tick();
    check_val("par_err_pulse", cnt_perr_b - pb, 1);
    check_val("par_no_ferr", cnt_ferr_b - fb0, 0);
    check_val("par_no_push", pops_b - p, 0);
    exp_q_b.push_back(8'h07);
    send(1, frame_b(8'h07, 1'b1, 1'b1), 12, -1);
    repeat (4) tick();
    check_val("par_ok_push", pops_b - p, 1);
    check_val("par_ok_no_err", cnt_perr_b - pb, 1);

    // Second stop bit low, line then held low: no restart until it returns high.
    send(1, frame_b(8'h55, 1'b0, 1'b0), 12, -1);
    repeat (40) tick();
    check_val("stop2_ferr", cnt_ferr_b - fb0, 1);
    check_val("stop2_no_perr", cnt_perr_b - pb, 1);
    check_val("stop2_held_idle", 32'(busy_b), 0);
    check_val("stop2_no_push", pops_b - p, 1);
    line_b = 1'b1;
    repeat (32) tick();
    exp_q_b.push_back(8'h3C);
    send(1, frame_b(8'h3C, 1'b0, 1'b1), 12, -1);
    repeat (4) tick();
    check_val("rearm_rx", pops_b - p, 2);
    check_val("b_no_ovr", cnt_ovr_b, 0);

    check_val("exp_q_a_left", 32'(exp_q_a.size()), 0);
    check_val("exp_q_b_left", 32'(exp_q_b.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
